// File: rtl/dyser.sv
// dyser: one slice of a configurable compute fabric. Eight input-port FIFOs
// are fed by two send lanes. Eight output ports each hold one configurable
// functional unit and a result FIFO, which two receive lanes drain.
module dyser #(
  parameter int DATA_WIDTH   = 63,
  parameter int FIFO_DEPTH   = 2,
  parameter int CONFIG_WORDS = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_WIDTH:0] send_data_r0,
  input  logic [DATA_WIDTH:0] send_data_r1,
  input  logic [2:0]          send_port_r0,
  input  logic [2:0]          send_port_r1,
  input  logic                send_en0,
  input  logic                send_en1,
  input  logic [2:0]          recv_port_r0,
  input  logic [2:0]          recv_port_r1,
  input  logic                recv_en0,
  input  logic                recv_en1,
  input  logic [20:0]         config_bits,
  input  logic                config_en,
  input  logic                commit,
  output logic                send_stall,
  output logic [DATA_WIDTH:0] recv_data_r0,
  output logic [DATA_WIDTH:0] recv_data_r1,
  output logic                recv_stall
);
  localparam int NPORT = 8;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = $clog2(CONFIG_WORDS + 1);

  typedef logic [DATA_WIDTH:0] word_t;

  // FIFOs are shift registers: entry 0 is always the head.
  word_t         in_mem_reg   [NPORT][FIFO_DEPTH];
  word_t         in_mem_next  [NPORT][FIFO_DEPTH];
  logic [CW-1:0] in_cnt_reg   [NPORT];
  logic [CW-1:0] in_cnt_next  [NPORT];
  word_t         out_mem_reg  [NPORT][FIFO_DEPTH];
  word_t         out_mem_next [NPORT][FIFO_DEPTH];
  logic [CW-1:0] out_cnt_reg  [NPORT];
  logic [CW-1:0] out_cnt_next [NPORT];

  // Only the meaningful fields [20:10] of each config word are kept.
  logic [10:0]   slot_reg [NPORT];
  logic [PW-1:0] ptr_reg;
  logic          unused_cfg_bits;

  logic [NPORT-1:0] fu_en;
  logic [3:0]       fu_op    [NPORT];
  logic [2:0]       fu_src_a [NPORT];
  logic [2:0]       fu_src_b [NPORT];
  word_t            fu_result [NPORT];
  logic [NPORT-1:0] fu_owns;
  logic [NPORT-1:0] fire;
  logic [NPORT-1:0] in_pop;
  logic             second_r1;

  assign unused_cfg_bits = ^config_bits[9:0];

  // Does an output with these sources/opcode read input port q?
  // Opcode 0 ignores its B operand, so it does not claim srcB.
  function automatic logic reads(input logic [2:0] a, input logic [2:0] b,
                                 input logic [3:0] op, input logic [2:0] q);
    return (a == q) || ((op != 4'd0) && (b == q));
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_fu
      word_t op_a;
      word_t op_b;
      word_t result;

      assign fu_en[gi]    = slot_reg[gi][10];
      assign fu_op[gi]    = slot_reg[gi][9:6];
      assign fu_src_a[gi] = slot_reg[gi][5:3];
      assign fu_src_b[gi] = slot_reg[gi][2:0];
      assign op_a         = in_mem_reg[fu_src_a[gi]][0];
      assign op_b         = in_mem_reg[fu_src_b[gi]][0];
      assign fu_result[gi] = result;

      // Functional unit datapath on the two source FIFO heads
      always_comb begin
        case (fu_op[gi])
          4'd0:    result = op_a;
          4'd1:    result = op_a + op_b;
          4'd2:    result = op_a - op_b;
          4'd3:    result = op_a & op_b;
          4'd4:    result = op_a | op_b;
          4'd5:    result = op_a ^ op_b;
          4'd6:    result = (op_a >= op_b) ? word_t'(1) : word_t'(0);
          4'd7:    result = (op_a <  op_b) ? word_t'(1) : word_t'(0);
          4'd8:    result = (op_a == op_b) ? word_t'(1) : word_t'(0);
          default: result = '0;
        endcase
      end
    end
  endgenerate

  // An input port belongs to the lowest-numbered enabled output reading it
  always_comb begin
    fu_owns = '0;
    for (int p = 0; p < NPORT; p++) begin
      fu_owns[p] = fu_en[p];
      for (int k = 0; k < NPORT; k++) begin
        if (k < p && fu_en[k]) begin
          if (reads(fu_src_a[k], fu_src_b[k], fu_op[k], fu_src_a[p]) ||
              ((fu_op[p] != 4'd0) &&
               reads(fu_src_a[k], fu_src_b[k], fu_op[k], fu_src_b[p])))
            fu_owns[p] = 1'b0;
        end
      end
    end
  end

  // Fire decision from start-of-cycle occupancy; config loading freezes the fabric
  always_comb begin
    fire   = '0;
    in_pop = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (fu_owns[p] && !config_en &&
          (in_cnt_reg[fu_src_a[p]] != '0) &&
          ((fu_op[p] == 4'd0) || (in_cnt_reg[fu_src_b[p]] != '0)) &&
          (out_cnt_reg[p] != CW'(FIFO_DEPTH))) begin
        fire[p] = 1'b1;
        in_pop[fu_src_a[p]] = 1'b1;
        if (fu_op[p] != 4'd0)
          in_pop[fu_src_b[p]] = 1'b1;
      end
    end
  end

  // Send is atomic: any enabled lane without room rejects both
  always_comb begin
    send_stall = 1'b0;
    for (int q = 0; q < NPORT; q++) begin
      int need;
      need = 0;
      if (send_en0 && (send_port_r0 == 3'(q))) need++;
      if (send_en1 && (send_port_r1 == 3'(q))) need++;
      if (need > FIFO_DEPTH - int'(in_cnt_reg[q]))
        send_stall = 1'b1;
    end
  end

  // Receive is atomic; lane 1 sees the second entry when lane 0 reads the same port
  always_comb begin
    second_r1  = recv_en0 && (recv_port_r0 == recv_port_r1);
    recv_stall = (recv_en0 && (out_cnt_reg[recv_port_r0] == '0)) ||
                 (recv_en1 && (second_r1 ? (out_cnt_reg[recv_port_r1] < CW'(2))
                                         : (out_cnt_reg[recv_port_r1] == '0)));
    recv_data_r0 = (out_cnt_reg[recv_port_r0] != '0) ? out_mem_reg[recv_port_r0][0] : '0;
    if (second_r1)
      recv_data_r1 = (out_cnt_reg[recv_port_r1] >= CW'(2)) ? out_mem_reg[recv_port_r1][1] : '0;
    else
      recv_data_r1 = (out_cnt_reg[recv_port_r1] != '0) ? out_mem_reg[recv_port_r1][0] : '0;
  end

  // Input FIFO next state: drop the popped head, then append lane 0 before lane 1
  always_comb begin
    for (int q = 0; q < NPORT; q++) begin
      logic push0;
      logic push1;
      int   keep;
      int   wr1;
      push0 = !send_stall && send_en0 && (send_port_r0 == 3'(q));
      push1 = !send_stall && send_en1 && (send_port_r1 == 3'(q));
      keep  = int'(in_cnt_reg[q]) - (in_pop[q] ? 1 : 0);
      wr1   = keep + (push0 ? 1 : 0);
      for (int i = 0; i < FIFO_DEPTH; i++)
        in_mem_next[q][i] = in_mem_reg[q][i];
      for (int i = 0; i < FIFO_DEPTH - 1; i++)
        if (in_pop[q]) in_mem_next[q][i] = in_mem_reg[q][i+1];
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (push0 && (i == keep)) in_mem_next[q][i] = send_data_r0;
        if (push1 && (i == wr1))  in_mem_next[q][i] = send_data_r1;
      end
      in_cnt_next[q] = CW'(wr1 + (push1 ? 1 : 0));
    end
  end

  // Output FIFO next state: drop received entries, then append the FU result
  always_comb begin
    for (int q = 0; q < NPORT; q++) begin
      int pop_n;
      int keep;
      pop_n = 0;
      if (!recv_stall && recv_en0 && (recv_port_r0 == 3'(q))) pop_n++;
      if (!recv_stall && recv_en1 && (recv_port_r1 == 3'(q))) pop_n++;
      keep = int'(out_cnt_reg[q]) - pop_n;
      for (int i = 0; i < FIFO_DEPTH; i++)
        out_mem_next[q][i] = out_mem_reg[q][i];
      for (int i = 0; i < FIFO_DEPTH - 1; i++)
        if (pop_n == 1) out_mem_next[q][i] = out_mem_reg[q][i+1];
      for (int i = 0; i + 2 < FIFO_DEPTH; i++)
        if (pop_n == 2) out_mem_next[q][i] = out_mem_reg[q][i+2];
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (fire[q] && (i == keep)) out_mem_next[q][i] = fu_result[q];
      out_cnt_next[q] = CW'(keep + (fire[q] ? 1 : 0));
    end
  end

  // State registers; commit flushes data and rewinds the pointer but keeps the slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < NPORT; q++) begin
        in_cnt_reg[q]  <= '0;
        out_cnt_reg[q] <= '0;
        slot_reg[q]    <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          in_mem_reg[q][i]  <= '0;
          out_mem_reg[q][i] <= '0;
        end
      end
      ptr_reg <= '0;
    end else if (commit) begin
      for (int q = 0; q < NPORT; q++) begin
        in_cnt_reg[q]  <= '0;
        out_cnt_reg[q] <= '0;
      end
      ptr_reg <= '0;
    end else begin
      for (int q = 0; q < NPORT; q++) begin
        in_cnt_reg[q]  <= in_cnt_next[q];
        out_cnt_reg[q] <= out_cnt_next[q];
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          in_mem_reg[q][i]  <= in_mem_next[q][i];
          out_mem_reg[q][i] <= out_mem_next[q][i];
        end
      end
      if (config_en) begin
        if (ptr_reg < PW'(NPORT))
          slot_reg[ptr_reg[2:0]] <= config_bits[20:10];
        if (ptr_reg < PW'(CONFIG_WORDS))
          ptr_reg <= ptr_reg + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dyser.sv
// tb_dyser: scoreboard bench for dyser. The driver computes expected outputs
// from a queue-based reference model and queues them; a negedge monitor
// compares them against the DUT.
`timescale 1ns/1ps
module tb_dyser;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] send_data_r0, send_data_r1;
  logic [2:0]  send_port_r0, send_port_r1;
  logic        send_en0, send_en1;
  logic [2:0]  recv_port_r0, recv_port_r1;
  logic        recv_en0, recv_en1;
  logic [20:0] config_bits;
  logic        config_en;
  logic        commit;
  logic        send_stall;
  logic [63:0] recv_data_r0, recv_data_r1;
  logic        recv_stall;

  dyser dut (
    .clk(clk), .rst(rst),
    .send_data_r0(send_data_r0), .send_data_r1(send_data_r1),
    .send_port_r0(send_port_r0), .send_port_r1(send_port_r1),
    .send_en0(send_en0), .send_en1(send_en1),
    .recv_port_r0(recv_port_r0), .recv_port_r1(recv_port_r1),
    .recv_en0(recv_en0), .recv_en1(recv_en1),
    .config_bits(config_bits), .config_en(config_en), .commit(commit),
    .send_stall(send_stall),
    .recv_data_r0(recv_data_r0), .recv_data_r1(recv_data_r1),
    .recv_stall(recv_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit se0, se1; logic [2:0] sp0, sp1; logic [63:0] sd0, sd1;
    bit re0, re1; logic [2:0] rp0, rp1;
    bit cen; logic [20:0] cbits; bit cmt;
  } stim_t;

  typedef struct {
    bit send_stall, recv_stall, re0, re1;
    logic [2:0] rp0, rp1;
    logic [63:0] d0, d1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference model: config slots, pointer, and plain queues per port
  logic [20:0] cfg [8];
  int          ptr;
  logic [63:0] inq  [8][$];
  logic [63:0] outq [8][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 8; q++) begin
      cfg[q] = '0; inq[q].delete(); outq[q].delete();
    end
    ptr = 0;
  endtask

  function automatic logic [63:0] fu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0: return a;
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return (a >= b) ? 64'd1 : 64'd0;
      4'd7: return (a <  b) ? 64'd1 : 64'd0;
      4'd8: return (a == b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  // Lowest enabled output that reads input port q (opcode 0 reads only srcA)
  function automatic int owner(input logic [2:0] q);
    for (int p = 0; p < 8; p++)
      if (cfg[p][20] && (cfg[p][15:13] == q || (cfg[p][19:16] != 4'd0 && cfg[p][12:10] == q)))
        return p;
    return -1;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.se0 = 0; s.se1 = 0; s.sp0 = 0; s.sp1 = 0; s.sd0 = 0; s.sd1 = 0;
    s.re0 = 0; s.re1 = 0; s.rp0 = 0; s.rp1 = 0;
    s.cen = 0; s.cbits = 0; s.cmt = 0;
    return s;
  endfunction

  function automatic stim_t snd(input int p0, input logic [63:0] d0, input int p1, input logic [63:0] d1);
    stim_t s;
    s = idle();
    s.se0 = (p0 >= 0); s.sp0 = 3'((p0 < 0) ? 0 : p0); s.sd0 = d0;
    s.se1 = (p1 >= 0); s.sp1 = 3'((p1 < 0) ? 0 : p1); s.sd1 = d1;
    return s;
  endfunction

  function automatic stim_t rcv(input int p0, input int p1);
    stim_t s;
    s = idle();
    s.re0 = (p0 >= 0); s.rp0 = 3'((p0 < 0) ? 0 : p0);
    s.re1 = (p1 >= 0); s.rp1 = 3'((p1 < 0) ? 0 : p1);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    send_en0 = s.se0; send_port_r0 = s.sp0; send_data_r0 = s.sd0;
    send_en1 = s.se1; send_port_r1 = s.sp1; send_data_r1 = s.sd1;
    recv_en0 = s.re0; recv_port_r0 = s.rp0;
    recv_en1 = s.re1; recv_port_r1 = s.rp1;
    config_en = s.cen; config_bits = s.cbits; commit = s.cmt;
  endtask

  // One clock cycle: drive, queue the expectation, advance the model
  task automatic cycle(input stim_t s);
    exp_t e;
    int need [8];
    int pos;
    bit fired [8];
    logic [63:0] res [8];
    drive(s);
    for (int q = 0; q < 8; q++) need[q] = 0;
    if (s.se0) need[s.sp0]++;
    if (s.se1) need[s.sp1]++;
    e.send_stall = 0;
    for (int q = 0; q < 8; q++)
      if (need[q] > D - inq[q].size()) e.send_stall = 1;
    pos = (s.re0 && s.rp0 == s.rp1) ? 1 : 0;
    e.recv_stall = (s.re0 && outq[s.rp0].size() < 1) || (s.re1 && outq[s.rp1].size() < pos + 1);
    e.re0 = s.re0; e.re1 = s.re1; e.rp0 = s.rp0; e.rp1 = s.rp1;
    e.d0 = (outq[s.rp0].size() > 0)   ? outq[s.rp0][0]   : 64'd0;
    e.d1 = (outq[s.rp1].size() > pos) ? outq[s.rp1][pos] : 64'd0;
    exp_q.push_back(e);

    if (s.cmt) begin
      for (int q = 0; q < 8; q++) begin inq[q].delete(); outq[q].delete(); end
      ptr = 0;
    end else begin
      for (int p = 0; p < 8; p++) begin
        logic [2:0] a, b;
        logic [3:0] op;
        a = cfg[p][15:13]; b = cfg[p][12:10]; op = cfg[p][19:16];
        fired[p] = 0; res[p] = 0;
        if (cfg[p][20] && !s.cen && owner(a) == p && (op == 0 || owner(b) == p) &&
            inq[a].size() > 0 && (op == 0 || inq[b].size() > 0) && outq[p].size() < D) begin
          fired[p] = 1;
          res[p] = fu(op, inq[a][0], (op == 0) ? 64'd0 : inq[b][0]);
        end
      end
      if (!e.recv_stall) begin
        if (s.re0) void'(outq[s.rp0].pop_front());
        if (s.re1) void'(outq[s.rp1].pop_front());
      end
      for (int p = 0; p < 8; p++) begin
        if (fired[p]) begin
          void'(inq[cfg[p][15:13]].pop_front());
          if (cfg[p][19:16] != 0 && cfg[p][12:10] != cfg[p][15:13])
            void'(inq[cfg[p][12:10]].pop_front());
          outq[p].push_back(res[p]);
        end
      end
      if (!e.send_stall) begin
        if (s.se0) inq[s.sp0].push_back(s.sd0);
        if (s.se1) inq[s.sp1].push_back(s.sd1);
      end
      if (s.cen) begin
        if (ptr < 8) cfg[ptr] = s.cbits;
        if (ptr < 17) ptr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " send_stall"}, 64'(send_stall), 64'd0);
    check({tag, " recv_stall"}, 64'(recv_stall), 64'd0);
    check({tag, " recv_data_r0"}, recv_data_r0, 64'd0);
    check({tag, " recv_data_r1"}, recv_data_r1, 64'd0);
  endtask

  // Monitor: compare the queued expectation for this cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("send_stall", 64'(send_stall), 64'(mon_e.send_stall));
      check("recv_stall", 64'(recv_stall), 64'(mon_e.recv_stall));
      if (mon_e.re0) check($sformatf("recv_data_r0 port%0d", mon_e.rp0), recv_data_r0, mon_e.d0);
      if (mon_e.re1) check($sformatf("recv_data_r1 port%0d", mon_e.rp1), recv_data_r1, mon_e.d1);
      if (!mon_e.recv_stall && mon_e.re0)
        $display("recv lane0 port %0d data %h", mon_e.rp0, recv_data_r0);
      if (!mon_e.recv_stall && mon_e.re1)
        $display("recv lane1 port %0d data %h", mon_e.rp1, recv_data_r1);
    end
  end

  logic [20:0] prog [17];
  int          rx_ports [8];

  initial begin
    stim_t s;
    rst = 1'b0;
    drive(idle());
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Arithmetic program
    prog = '{21'h164400, 21'h128C00, 21'h0, 21'h121C00, 21'h0, 21'h16D400,
             21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0, 21'h0};
    for (int i = 0; i < 17; i++) begin
      s = idle(); s.cen = 1; s.cbits = prog[i]; cycle(s);
    end
    cycle(snd(4, 0, 3, 1));       cycle(snd(2, 2, 1, 3));
    cycle(snd(6, 4, 5, 5));       cycle(snd(0, 6, 7, 7));
    cycle(snd(4, 4, 3, 4));       cycle(snd(2, 'h55, 1, 'hFF));
    cycle(snd(6, 'hFF, 5, 'h55)); cycle(snd(0, 5, 7, 'hA));
    cycle(idle()); cycle(idle());
    rx_ports = '{1, 1, 0, 0, 5, 5, 3, 3};
    for (int i = 0; i < 8; i++) cycle(rcv(rx_ports[i], -1));

    // Send backpressure on port 2, then verify which values were kept
    cycle(snd(2, 'h11, -1, 0)); cycle(snd(2, 'h22, -1, 0)); cycle(snd(2, 'h33, -1, 0));
    cycle(snd(1, 'h11, -1, 0)); cycle(snd(1, 'h30, -1, 0));
    cycle(idle()); cycle(idle());
    cycle(rcv(0, -1)); cycle(rcv(0, -1));
    cycle(snd(6, 'h1, -1, 0)); cycle(snd(6, 'h2, 6, 'h3)); cycle(snd(6, 'h4, -1, 0));
    s = idle(); s.cmt = 1; cycle(s);

    // Receive stall until a result appears
    cycle(rcv(1, -1));
    s = snd(4, 9, 3, 2); s.re0 = 1; s.rp0 = 1; cycle(s);
    repeat (3) cycle(rcv(1, -1));

    // Dual receive from one port
    cycle(snd(4, 10, 3, 3)); cycle(snd(4, 20, 3, 5));
    cycle(idle()); cycle(idle());
    cycle(rcv(1, 1)); cycle(rcv(1, -1));

    // Commit with data queued; config survives
    cycle(snd(4, 1, 3, 1)); cycle(snd(0, 8, 7, 3)); cycle(idle());
    s = idle(); s.cmt = 1; cycle(s);
    cycle(rcv(1, 3));
    cycle(snd(4, 100, 3, 1)); cycle(idle()); cycle(idle());
    cycle(rcv(1, -1));

    // Randomized rounds: random program, random traffic
    for (int r = 0; r < 3; r++) begin
      s = idle(); s.cmt = 1; cycle(s);
      for (int i = 0; i < 17; i++) begin
        s = idle(); s.cen = 1;
        s.cbits = {1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 10'($urandom)};
        cycle(s);
      end
      for (int c = 0; c < 150; c++) begin
        s = idle();
        s.se0 = ($urandom_range(0, 1) == 1); s.sp0 = 3'($urandom_range(0, 7));
        s.se1 = ($urandom_range(0, 2) == 0); s.sp1 = 3'($urandom_range(0, 7));
        s.sd0 = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
        s.sd1 = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
        s.re0 = ($urandom_range(0, 1) == 1); s.rp0 = 3'($urandom_range(0, 7));
        s.re1 = ($urandom_range(0, 2) == 0); s.rp1 = 3'($urandom_range(0, 7));
        s.cen = ($urandom_range(0, 19) == 0); s.cbits = 21'($urandom);
        s.cmt = !s.cen && ($urandom_range(0, 59) == 0);
        cycle(s);
      end
    end

    // Asynchronous reset in mid-stream
    s = idle(); s.cmt = 1; cycle(s);
    for (int i = 0; i < 17; i++) begin
      s = idle(); s.cen = 1; s.cbits = prog[i]; cycle(s);
    end
    cycle(snd(4, 5, 3, 1)); cycle(idle());
    drive(idle());
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_quiet("midreset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cycle(snd(4, 5, 3, 1)); cycle(idle()); cycle(idle());
    cycle(rcv(1, -1)); cycle(rcv(0, 5));

    drive(idle());
    repeat (3) @(posedge clk);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dyser.md
Name: dyser

Overview:
- Configurable compute fabric (DySER accelerator slice) attached to a core pipeline.
- Eight 64-bit input ports receive operands through two send lanes. Eight output ports each hold one configurable functional unit (FU) that computes on two input-port streams.
- Results are read back through two receive lanes.
- Configuration is loaded word-by-word over config_bits/config_en.

Parameters:
- DATA_WIDTH, 63, MSB index of data buses (bus width DATA_WIDTH+1 = 64)
- FIFO_DEPTH, 2, entries per input-port and per output-port FIFO
- CONFIG_WORDS, 17, config words per full load; words 8..16 are reserved and ignored

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- send_data_r0/r1  in  DATA_WIDTH+1  send lane 0/1 data
- send_port_r0/r1  in  3  destination input port for lane 0/1
- send_en0/en1  in  1  send lane 0/1 valid
- recv_port_r0/r1  in  3  output port to read on lane 0/1
- recv_en0/en1  in  1  receive lane 0/1 request
- config_bits  in  21  configuration word
- config_en  in  1  configuration word valid
- commit  in  1  flush data state and restart config pointer
- send_stall  out  1  send rejected this cycle
- recv_data_r0/r1  out  DATA_WIDTH+1  receive lane 0/1 data
- recv_stall  out  1  receive rejected this cycle

Behaviour:
- Reset (rst low, async):
  - all FIFOs empty; all 8 output configs cleared (disabled); config pointer = 0.
  - Combinational outputs then read 0 with no requests pending.
- Config load:
  - Each rising edge with config_en=1 writes config_bits to slot[pointer] if pointer<8; words at pointer 8..16 are discarded.
  - Pointer increments and saturates at CONFIG_WORDS.
  - Slot p configures output port p with these fields:
    - [20] enable
    - [19:16] opcode
    - [15:13] srcA input port
    - [12:10] srcB input port
    - [9:0] reserved
- Opcodes (unsigned, results truncated to 64 bits):
  - 0 A (uses A only)
  - 1 A+B
  - 2 A-B
  - 3 A&B
  - 4 A|B
  - 5 A^B
  - 6 (A>=B)?1:0
  - 7 (A<B)?1:0
  - 8 (A==B)?1:0
  - 9-15 result 0
- Send:
  - Each lane with en=1 pushes its data into the FIFO of its input port.
  - send_stall (combinational) = 1 if any enabled push lacks space. Both lanes to the same port require 2 free slots.
  - When send_stall=1, neither lane is accepted (atomic).
  - When both lanes target the same port, lane 0 is enqueued before lane 1.
- Fire:
  - An enabled output p fires at a rising edge when its srcA FIFO is non-empty, its srcB FIFO is non-empty (unless opcode 0), its output FIFO is not full, and config_en=0.
  - Firing pops the operand heads and pushes the result.
  - Input-port ownership: an input port is consumed only by the lowest-numbered enabled output referencing it. Other outputs referencing it never fire.
  - If srcA==srcB, the output fires with A=B=head and pops once.
  - Latency: data sent at edge N is used at edge N+1. The result is readable after edge N+1.
  - Fire and send may occur in the same cycle. A FIFO full at the start of the cycle still stalls the send; there is no bypass.
- Receive:
  - recv_data_rX (combinational) = head of FIFO[recv_port_rX] if non-empty, else 0.
  - If both lanes request the same port, lane 1 sees the second entry.
  - recv_stall (combinational) = 1 if any enabled lane lacks an available entry. When stalled, no lane pops (atomic).
  - Otherwise each enabled lane pops at the rising edge.
- commit (sync, rising edge): empties all FIFOs and sets pointer=0; the config slots are retained. It overrides same-cycle sends, receives and fires.
- Unconfigured output: its FIFO never fills, so a receive from it stalls indefinitely.

Test Plan:
- Arithmetic program:
  - Load words 0x164400, 0x128C00, 0, 0x121C00, 0, 0x16D400, then 11 zeros.
  - Send pairs (4:0,3:1), (2:2,1:3), (6:4,5:5), (0:6,7:7), (4:4,3:4), (2:0x55,1:0xFF), (6:0xFF,5:0x55), (0:5,7:0xA).
  - Receive on lane 0: port1 -> 0xFFFFFFFFFFFFFFFF then 0.
  - port0 -> 0 then 0.
  - port5 -> 0 then 1.
  - port3 -> 0xFFFFFFFFFFFFFFFF then 0xFFFFFFFFFFFFFFFB.
  - No stalls are expected.
- Send backpressure: three single-lane sends to port 2 with no consumer -> third cycle send_stall=1 and the FIFO keeps the first two values. A dual-lane send to a port with one free slot -> stall, nothing accepted.
- Receive stall: recv_en0 on port 1 before any send -> recv_stall=1, recv_data_r0=0. Then send 9 to port 4 and 2 to port 3 -> recv_stall falls one cycle later and data reads 7.
- Dual receive: two results queued on port 1, both lanes read port 1 -> lane 0 = older, lane 1 = newer, FIFO empty after.
- Commit/reset: with data queued, assert commit -> all FIFOs empty and the config still works on new sends. Drive rst low mid-stream -> outputs and stalls 0, all outputs disabled.
